// File: rtl/bloom_scan_pkg.sv
// Shared types and elaboration helpers for the Bloom-filter page scanner.
//   scan_state_e : scanner FSM states
//   calc_nop     : pages held in the candidate array
//   calc_width   : index width for a count of items (never below 1)
//   lowest_set   : position of the least-significant set bit of a vector
package bloom_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      EXT  = 2'd2,
      DONE = 2'd3
   } scan_state_e;

   // Widest match mask lowest_set() can search; the top checks PPB against it.
   localparam int LSB_W = 64;

   function automatic int calc_nop(input int arr_size, input int p_size);
      return arr_size / p_size;
   endfunction

   function automatic int calc_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Scans from the top down so the last bit seen, the lowest, wins.
   function automatic int lowest_set(input logic [LSB_W-1:0] v);
      int idx;
      idx = 0;
      for (int i = LSB_W - 1; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/page_match_unit.sv
// Compares one page against every pattern; purely combinational.
//   page   : P_SIZE-bit page under test
//   pats   : NPAT patterns, pattern n at pats[n*P_SIZE +: P_SIZE]
//   pat_en : per-pattern enable, a disabled pattern never matches
//   match  : page equals at least one enabled pattern
module page_match_unit #(
   parameter int P_SIZE = 12,
   parameter int NPAT   = 4
) (
   input  logic [P_SIZE-1:0]      page,
   input  logic [NPAT*P_SIZE-1:0] pats,
   input  logic [NPAT-1:0]        pat_en,
   output logic                   match
);

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves match unassigned, which would infer a latch.
      match = 1'b0;
      for (int n = 0; n < NPAT; n++) begin
         if (pat_en[n] && (pats[n*P_SIZE +: P_SIZE] == page)) match = 1'b1;
      end
   end

endmodule

// File: rtl/bloom_page_scanner.sv
// Multi-pattern page scanner for the Bloom-filter FTL lookup path.
// Latches the candidate array and patterns on start, walks one block of PPB
// pages per epoch, and compacts matching global page indices, one per cycle,
// into an ascending hit list.
//   clk, rst  : rising-edge clock, asynchronous active-low reset
//   start     : request a scan, accepted only while idle
//   arr_in    : candidate array, page p at arr_in[p*P_SIZE +: P_SIZE]
//   pat_in    : patterns, pattern n at pat_in[n*P_SIZE +: P_SIZE]
//   pat_en    : per-pattern enable
//   busy      : scan in progress (cycle after acceptance through DONE)
//   done      : one-cycle pulse, results valid
//   hit_list  : slot h at hit_list[h*NOP_W +: NOP_W]; unused slots read 0
//   hit_cnt   : number of valid slots
//   overflow  : more than MAX_HITS matches were found in this scan
module bloom_page_scanner
   import bloom_scan_pkg::*;
#(
   parameter  int ARR_SIZE = 288,
   parameter  int P_SIZE   = 12,
   parameter  int PPB      = 8,
   parameter  int NPAT     = 4,
   parameter  int MAX_HITS = 8,
   localparam int NOP      = calc_nop(ARR_SIZE, P_SIZE),
   localparam int NOB      = NOP / PPB,
   localparam int NOP_W    = calc_width(NOP),
   localparam int NOB_W    = $clog2(NOB) + 1,
   localparam int CNT_W    = $clog2(MAX_HITS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ARR_SIZE-1:0]       arr_in,
   input  logic [NPAT*P_SIZE-1:0]    pat_in,
   input  logic [NPAT-1:0]           pat_en,
   output logic                      busy,
   output logic                      done,
   output logic [MAX_HITS*NOP_W-1:0] hit_list,
   output logic [CNT_W-1:0]          hit_cnt,
   output logic                      overflow
);

   localparam int BLK_W = PPB * P_SIZE;

   if (ARR_SIZE % (P_SIZE * PPB) != 0) begin : g_bad_size
      $error("bloom_page_scanner: ARR_SIZE must be a multiple of P_SIZE*PPB");
   end
   if (PPB > LSB_W) begin : g_bad_ppb
      $error("bloom_page_scanner: PPB exceeds the lowest_set search width");
   end

   scan_state_e             state, state_n;
   logic [ARR_SIZE-1:0]     arr_q;
   logic [NPAT*P_SIZE-1:0]  pat_q;
   logic [NPAT-1:0]         en_q;
   logic [NOB_W-1:0]        epoch;
   logic [PPB-1:0]          mask;
   logic [PPB-1:0]          match_vec;
   logic [BLK_W-1:0]        blk;
   logic [NOP_W-1:0]        hit_idx;
   logic                    accept, load_mask, take_hit, next_epoch;

   // Block under comparison this epoch.
   assign blk = arr_q[int'(epoch)*BLK_W +: BLK_W];

   for (genvar i = 0; i < PPB; i++) begin : g_pm
      page_match_unit #(
         .P_SIZE (P_SIZE),
         .NPAT   (NPAT)
      ) u_pm (
         .page   (blk[i*P_SIZE +: P_SIZE]),
         .pats   (pat_q),
         .pat_en (en_q),
         .match  (match_vec[i])
      );
   end

   // Global page index of the lowest pending match; always below NOP.
   assign hit_idx = NOP_W'(epoch) * NOP_W'(PPB) + NOP_W'(lowest_set(LSB_W'(mask)));

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n    = state;
      accept     = 1'b0;
      load_mask  = 1'b0;
      take_hit   = 1'b0;
      next_epoch = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_n = CMP;
            end
         end
         CMP: begin
            load_mask = 1'b1;
            state_n   = EXT;
         end
         EXT: begin
            if (mask != '0) begin
               take_hit = 1'b1;
            end else if (epoch == NOB_W'(NOB - 1)) begin
               state_n = DONE;
            end else begin
               next_epoch = 1'b1;
               state_n    = CMP;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arr_q    <= '0;
         pat_q    <= '0;
         en_q     <= '0;
         epoch    <= '0;
         mask     <= '0;
         // NOTE: the hit list is a reset register, not a RAM, because unused slots must read 0 at all times.
         hit_list <= '0;
         hit_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            arr_q    <= arr_in;
            pat_q    <= pat_in;
            en_q     <= pat_en;
            epoch    <= '0;
            mask     <= '0;
            hit_list <= '0;
            hit_cnt  <= '0;
            overflow <= 1'b0;
         end
         if (load_mask)  mask  <= match_vec;
         if (next_epoch) epoch <= epoch + NOB_W'(1);
         if (take_hit) begin
            mask <= mask & (mask - PPB'(1));
            // Once full, further matches only flag overflow so the list stays ascending.
            if (hit_cnt < CNT_W'(MAX_HITS)) begin
               hit_list[int'(hit_cnt)*NOP_W +: NOP_W] <= hit_idx;
               hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/bloom_page_scanner.md
# bloom_page_scanner

Parametrised, multi-pattern page scanner for the Bloom-filter FTL lookup path. Latches an ARR_SIZE-bit candidate array and NPAT page-size patterns on `start`. Walks the array one block (PPB pages) per epoch under an internal FSM and compacts the global indices of matching pages into an ordered hit list. The hit list is built one hit per cycle, so the number of hits per epoch is data-dependent with no dynamic loop bounds. The result is read by the FTL mapping logic after `done`.

## Interface
Parameters:
- ARR_SIZE, 288, bits in candidate array
- P_SIZE, 12, bits per page/pattern
- PPB, 8, pages compared per epoch
- NPAT, 4, number of patterns
- MAX_HITS, 8, capacity of hit list
- Derived: NOP = ARR_SIZE/P_SIZE, NOB = NOP/PPB, NOP_W = $clog2(NOP), NOB_W = $clog2(NOB)+1, CNT_W = $clog2(MAX_HITS+1)
- Elaboration error unless ARR_SIZE % (P_SIZE*PPB) == 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request scan; accepted only in IDLE
- arr_in  in  ARR_SIZE  candidate array; page p = arr_in[p*P_SIZE +: P_SIZE]
- pat_in  in  NPAT*P_SIZE  patterns; pattern n = pat_in[n*P_SIZE +: P_SIZE]
- pat_en  in  NPAT  per-pattern enable; disabled pattern never matches
- busy  out  1  high from the cycle after start is accepted until DONE completes
- done  out  1  one-cycle pulse, result valid
- hit_list  out  MAX_HITS*NOP_W  slot h = hit_list[h*NOP_W +: NOP_W], ascending page order
- hit_cnt  out  CNT_W  valid slots
- overflow  out  1  sticky; more than MAX_HITS matches were found

## Operation
- Reset: FSM to IDLE. busy=0, done=0, hit_list=0, hit_cnt=0, overflow=0. Internal array/pattern/mask/epoch registers cleared.
- FSM states: IDLE, CMP, EXT, DONE.
- IDLE: on start=1, latch arr_in, pat_in and pat_en. Clear hit_list, hit_cnt and overflow. Set epoch=0 and go to CMP. Otherwise hold previous results.
- CMP: compare the PPB pages of block `epoch` against all enabled patterns. A page matches if it is bitwise equal to any enabled pattern. Register the PPB-bit match mask, then go to EXT.
- EXT, mask != 0: select the lowest set bit j and clear it.
  - If hit_cnt < MAX_HITS: write epoch*PPB+j into slot hit_cnt, then hit_cnt++.
  - Else: set overflow; hit_cnt and hit_list are unchanged.
  - Stay in EXT.
- EXT, mask == 0: if epoch == NOB-1, go to DONE; else epoch++ and go to CMP.
- DONE: done=1 for this cycle only, then go to IDLE. busy drops on entry to IDLE.
- start while not in IDLE is ignored. Inputs are sampled only at acceptance; later changes to them have no effect.
- Index arithmetic is done at NOP_W bits. epoch*PPB+j < NOP always.
- Slots at index ≥ hit_cnt read 0.

## Timing
- Start accepted at edge t0. Cycle count for K total matches (including overflowed ones): done is high in cycle 2*NOB+1+K after t0.
- Defaults with no hits: done in cycle 7.
- Each epoch costs 2 + (matches in that epoch) cycles.
- Outputs are registered and stable from the done cycle until the next accepted start.
- Back-to-back: start may be asserted in the cycle after done (IDLE).
- Reset asserted mid-scan: immediate return to reset values. A partial hit list is not preserved.
- start and rst deassertion in the same cycle: start is ignored on that edge only if rst is still low at the edge.

## Structure
- Package `bloom_scan_pkg`:
  - state enum `scan_state_e` (IDLE, CMP, EXT, DONE)
  - localparam helper functions for NOP, NOB and widths
  - lowest-set-bit function used by EXT
- Sub-module `page_match_unit`:
  - one P_SIZE page vs NPAT patterns with pat_en
  - 1-bit output
  - PPB instances, combinational
- Top holds the FSM, the latched inputs, epoch counter, mask register and hit list.

## Test plan
- Defaults, all pages 0xABC, pat_in = {0x111,0x222,0x333,0x444}, pat_en=4'hF -> done at cycle 7, hit_cnt=0, hit_list=0, overflow=0.
- Page 3 = 0x5A5 = pattern 2, page 17 = 0x0F0 = pattern 0, rest 0xFFF with pattern 3 = 0xFFF and pat_en=4'b0101 -> hit_list slots {3,17}, hit_cnt=2, done at cycle 9.
- Same array, pat_en=4'b0000 -> hit_cnt=0. Then repeat with pat_en=4'b0001 -> hit_cnt=1, slot0=17 (previous results cleared).
- All 24 pages equal pattern 1 -> slots 0..7 = 0..7, hit_cnt=8, overflow=1, done at cycle 31.
- Assert rst low during EXT of epoch 1 after 2 hits -> all outputs 0 next cycle. A new start runs a full scan with correct results.
- start held high through a scan, and arr_in changed mid-scan -> exactly one scan per done. Results reflect the values at acceptance. Second scan begins the cycle after done.
